calc_controller: RTL and testbench
==================================

Name: calc_controller

Overview:
Sequencer that turns keypad key events into one calculator operation on the shared 11-bit signed ALU (add/subtract/multiply/divide, registered, one-cycle latency after compute strobe). It builds operands A and B from decimal digit entry, drives the ALU operand/opcode/strobe lines, and captures result and remainder for the display mux. It also handles divide-by-zero, operand clamping and chaining a result into the next operation.

Parameters:
MAX_DIGITS, 3, max decimal digits per operand magnitude (999 max)
ALU_LATENCY, 1, clock cycles from strobe edge to valid ALU result

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high; clears all state
key_valid  input  1  one-cycle pulse, key_code valid
key_code  input  5  0-9 digit, 10 add, 11 subtract, 12 multiply, 13 divide, 14 equals, 15 clear, 16 negate; others ignored
alu_a  output  11  signed operand A to ALU regA
alu_b  output  11  signed operand B to ALU regB
alu_op  output  2  00 add, 01 sub, 10 mul, 11 div
alu_strobe  output  1  one-cycle compute strobe to ALU
alu_result  input  21  signed ALU result
alu_remain  input  1  ALU remainder-valid flag
alu_remainder  input  21  ALU remainder magnitude
display_value  output  21  signed value for display
display_remainder  output  21  captured remainder
show_remainder  output  1  display remainder field
busy  output  1  high in COMPUTE/WAIT; keys ignored
error  output  1  high in ERROR state

Behaviour:
- Reset (async, any state including mid-compute): state ENTRY_A; A, B, op, digit counts, sign flags, captured result/remainder = 0; all outputs 0.
- States: ENTRY_A, OP_WAIT, ENTRY_B, COMPUTE, WAIT, SHOW, ERROR.
- Digit entry: mag <= mag*10 + digit while digit count < MAX_DIGITS; extra digits ignored. Leading zeros do not increase count. Operand = sign ? -mag : mag; negate toggles sign flag; -0 drives 0.
- ENTRY_A: digit/negate edit A; operator latches op -> OP_WAIT; equals ignored.
- OP_WAIT: operator replaces op; digit starts B (B=digit, count 1) -> ENTRY_B; negate sets B sign, stays; equals ignored.
- ENTRY_B: digit/negate edit B; operator ignored; equals -> COMPUTE, unless op=divide and B=0 -> ERROR, no strobe.
- COMPUTE: alu_strobe=1 for exactly one cycle, alu_a/alu_b/alu_op held stable from COMPUTE through capture -> WAIT.
- WAIT: counts ALU_LATENCY cycles after strobe edge, then captures alu_result -> display_value; if op=divide, captures alu_remainder and sets show_remainder = alu_remain; -> SHOW.
- SHOW: digit clears everything, starts new A with that digit -> ENTRY_A; operator: if result in -999..999, load A = result, latch op -> OP_WAIT; else -> ERROR; equals/negate ignored.
- ERROR: error=1, display_value=0; only clear exits.
- clear (code 15) in any state except COMPUTE/WAIT: same as reset. During COMPUTE/WAIT every key incl. clear ignored; no queuing.
- display_value: current operand in ENTRY_A/ENTRY_B, A in OP_WAIT, result in SHOW. show_remainder cleared on leaving SHOW.
- busy = 1 in COMPUTE and WAIT only. Result ready exactly 2+ALU_LATENCY-1 cycles after equals key (equals -> COMPUTE -> WAIT -> SHOW).
- Simultaneous key_valid with busy: dropped.

Test Plan:
- Keys 1,2,add,3,4,equals -> single strobe with alu_a=12, alu_b=34, op=00; SHOW display_value=46, show_remainder=0.
- 5,sub,9,equals -> display_value=-4; then 7 -> ENTRY_A, display_value=7.
- 9,9,9,mul,9,9,9,negate,equals -> alu_b=-999, display_value=-998001; then add -> ERROR, error=1, clear -> ENTRY_A, all zero.
- 7,negate,div,2,equals -> alu_a=-7; display_value=-4, display_remainder=1, show_remainder=1.
- 8,div,0,equals -> ERROR, alu_strobe never asserted, display_value=0.
- 1,2,3,4,mul,3,equals,add,4,equals -> A clamps to 123, display 369, chained A=369, final display_value=373; keys pressed while busy ignored; reset asserted during WAIT -> immediate ENTRY_A, outputs 0.

Source files
------------

// File: rtl/calc_controller.sv
// Keypad-driven calculator sequencer: builds two decimal operands, issues one
// ALU operation, captures result/remainder and supports chaining into the next op.
`timescale 1ns/1ps
module calc_controller #(
    parameter int MAX_DIGITS  = 3,
    parameter int ALU_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [10:0] alu_a,
    output logic [10:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_strobe,
    input  logic [20:0] alu_result,
    input  logic        alu_remain,
    input  logic [20:0] alu_remainder,
    output logic [20:0] display_value,
    output logic [20:0] display_remainder,
    output logic        show_remainder,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {ENTRY_A, OP_WAIT, ENTRY_B, COMPUTE, WAIT, SHOW, ERROR} state_t;

    localparam logic [3:0] CNT_MAX   = 4'(MAX_DIGITS);
    localparam logic [3:0] WAIT_LAST = 4'(ALU_LATENCY - 1);
    localparam logic [1:0] OP_DIV    = 2'b11;

    state_t      state_reg, state_next;
    logic [9:0]  a_mag_reg, b_mag_reg;
    logic [3:0]  a_cnt_reg, b_cnt_reg;
    logic        a_neg_reg, b_neg_reg;
    logic [1:0]  op_reg;
    logic [20:0] result_reg, rem_reg;
    logic        show_rem_reg;
    logic [3:0]  wait_cnt_reg;

    logic        is_digit, is_op, is_eq, is_clr, is_neg, key_ok, wait_done, in_range;
    logic [3:0]  digit;
    logic [4:0]  op_off;
    logic [1:0]  key_op;
    logic [20:0] res_abs;

    function automatic logic [9:0] push_mag(input logic [9:0] mag, input logic [3:0] d);
        logic [13:0] t;
        t = {4'b0, mag} * 14'd10 + {10'b0, d};
        return t[9:0];
    endfunction

    // Leading zeros leave both magnitude and digit count untouched.
    function automatic logic can_push(input logic [9:0] mag, input logic [3:0] cnt,
                                      input logic [3:0] d);
        return (cnt < CNT_MAX) && ((mag != 10'd0) || (d != 4'd0));
    endfunction

    function automatic logic [10:0] to_op(input logic [9:0] mag, input logic neg);
        return neg ? (~{1'b0, mag} + 11'd1) : {1'b0, mag};
    endfunction

    assign busy      = (state_reg == COMPUTE) || (state_reg == WAIT);
    assign is_digit  = key_code <= 5'd9;
    assign is_op     = (key_code >= 5'd10) && (key_code <= 5'd13);
    assign is_eq     = key_code == 5'd14;
    assign is_clr    = key_code == 5'd15;
    assign is_neg    = key_code == 5'd16;
    assign digit     = key_code[3:0];
    assign op_off    = key_code - 5'd10;
    assign key_op    = op_off[1:0];
    assign key_ok    = key_valid && !busy;
    assign wait_done = wait_cnt_reg == WAIT_LAST;
    assign in_range  = ($signed(result_reg) >= -21'sd999) && ($signed(result_reg) <= 21'sd999);
    assign res_abs   = result_reg[20] ? (~result_reg + 21'd1) : result_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_reg <= ENTRY_A;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENTRY_A: if (key_ok && is_op) state_next = OP_WAIT;
            OP_WAIT: if (key_ok && is_digit) state_next = ENTRY_B;
            ENTRY_B: if (key_ok && is_eq)
                         state_next = (op_reg == OP_DIV && b_mag_reg == 10'd0) ? ERROR : COMPUTE;
            COMPUTE: state_next = WAIT;
            WAIT:    if (wait_done) state_next = SHOW;
            SHOW: begin
                if (key_ok && is_digit) state_next = ENTRY_A;
                else if (key_ok && is_op) state_next = in_range ? OP_WAIT : ERROR;
            end
            default: state_next = state_reg;
        endcase
        if (key_ok && is_clr) state_next = ENTRY_A;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_mag_reg <= '0; a_cnt_reg <= '0; a_neg_reg <= 1'b0;
            b_mag_reg <= '0; b_cnt_reg <= '0; b_neg_reg <= 1'b0;
            op_reg <= '0; result_reg <= '0; rem_reg <= '0;
            show_rem_reg <= 1'b0; wait_cnt_reg <= '0;
        end else begin
            wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 4'd1 : 4'd0;
            if (state_reg == WAIT && wait_done) begin
                result_reg <= alu_result;
                if (op_reg == OP_DIV) begin
                    rem_reg      <= alu_remainder;
                    show_rem_reg <= alu_remain;
                end
            end
            if (key_ok && is_clr) begin
                a_mag_reg <= '0; a_cnt_reg <= '0; a_neg_reg <= 1'b0;
                b_mag_reg <= '0; b_cnt_reg <= '0; b_neg_reg <= 1'b0;
                op_reg <= '0; result_reg <= '0; rem_reg <= '0; show_rem_reg <= 1'b0;
            end else if (key_ok) begin
                case (state_reg)
                    ENTRY_A: begin
                        if (is_digit && can_push(a_mag_reg, a_cnt_reg, digit)) begin
                            a_mag_reg <= push_mag(a_mag_reg, digit);
                            a_cnt_reg <= a_cnt_reg + 4'd1;
                        end
                        if (is_neg) a_neg_reg <= ~a_neg_reg;
                        if (is_op)  op_reg <= key_op;
                    end
                    OP_WAIT: begin
                        if (is_op) op_reg <= key_op;
                        if (is_digit) begin
                            b_mag_reg <= {6'b0, digit};
                            b_cnt_reg <= (digit != 4'd0) ? 4'd1 : 4'd0;
                        end
                        if (is_neg) b_neg_reg <= ~b_neg_reg;
                    end
                    ENTRY_B: begin
                        if (is_digit && can_push(b_mag_reg, b_cnt_reg, digit)) begin
                            b_mag_reg <= push_mag(b_mag_reg, digit);
                            b_cnt_reg <= b_cnt_reg + 4'd1;
                        end
                        if (is_neg) b_neg_reg <= ~b_neg_reg;
                    end
                    SHOW: begin
                        if (is_digit) begin
                            a_mag_reg <= {6'b0, digit};
                            a_cnt_reg <= (digit != 4'd0) ? 4'd1 : 4'd0;
                            a_neg_reg <= 1'b0;
                            b_mag_reg <= '0; b_cnt_reg <= '0; b_neg_reg <= 1'b0;
                            op_reg <= '0; result_reg <= '0; rem_reg <= '0;
                            show_rem_reg <= 1'b0;
                        end else if (is_op) begin
                            show_rem_reg <= 1'b0;
                            // Chained result becomes A; it is already a full operand.
                            if (in_range) begin
                                a_mag_reg <= res_abs[9:0];
                                a_neg_reg <= result_reg[20];
                                a_cnt_reg <= CNT_MAX;
                                b_mag_reg <= '0; b_cnt_reg <= '0; b_neg_reg <= 1'b0;
                                op_reg <= key_op;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        alu_a             = to_op(a_mag_reg, a_neg_reg);
        alu_b             = to_op(b_mag_reg, b_neg_reg);
        alu_op            = op_reg;
        alu_strobe        = state_reg == COMPUTE;
        error             = state_reg == ERROR;
        display_remainder = rem_reg;
        show_remainder    = show_rem_reg;
        case (state_reg)
            ENTRY_A, OP_WAIT:      display_value = {{10{alu_a[10]}}, alu_a};
            ENTRY_B, COMPUTE, WAIT: display_value = {{10{alu_b[10]}}, alu_b};
            SHOW:                  display_value = result_reg;
            default:               display_value = '0;
        endcase
    end
endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: key-vector table plus hand sequences for
// busy-key dropping, compute latency and reset during WAIT. Includes a simple ALU model.
`timescale 1ns/1ps
module tb_calc_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic [10:0] alu_a, alu_b;
    logic [1:0]  alu_op;
    logic        alu_strobe;
    logic [20:0] alu_result = '0;
    logic        alu_remain = 1'b0;
    logic [20:0] alu_remainder = '0;
    logic [20:0] display_value, display_remainder;
    logic        show_remainder, busy, error;

    calc_controller #(.MAX_DIGITS(3), .ALU_LATENCY(1)) dut (
        .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_strobe(alu_strobe),
        .alu_result(alu_result), .alu_remain(alu_remain), .alu_remainder(alu_remainder),
        .display_value(display_value), .display_remainder(display_remainder),
        .show_remainder(show_remainder), .busy(busy), .error(error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_miss = 0;
    int strobe_cnt = 0;
    int last_a = 0, last_b = 0, last_op = 0;

    // Floor division with a non-negative remainder.
    function automatic int alu_calc(input int a, input int b, input int op, input bit want_rem);
        int q, r;
        case (op)
            0: return want_rem ? 0 : a + b;
            1: return want_rem ? 0 : a - b;
            2: return want_rem ? 0 : a * b;
            default: begin
                if (b == 0) return 0;
                q = a / b;
                r = a % b;
                if (r != 0 && ((r < 0) != (b < 0))) begin
                    q = q - 1;
                    r = r + b;
                end
                if (r < 0) r = -r;
                return want_rem ? r : q;
            end
        endcase
    endfunction

    always @(posedge clock) begin
        if (alu_strobe) begin
            strobe_cnt    <= strobe_cnt + 1;
            last_a        <= int'($signed(alu_a));
            last_b        <= int'($signed(alu_b));
            last_op       <= int'(alu_op);
            alu_result    <= 21'(alu_calc(int'($signed(alu_a)), int'($signed(alu_b)), int'(alu_op), 1'b0));
            alu_remainder <= 21'(alu_calc(int'($signed(alu_a)), int'($signed(alu_b)), int'(alu_op), 1'b1));
            alu_remain    <= (alu_op == 2'b11) &&
                             (alu_calc(int'($signed(alu_a)), int'($signed(alu_b)), int'(alu_op), 1'b1) != 0);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int disp_s();
        return int'($signed(display_value));
    endfunction

    task automatic press(input logic [4:0] k);
        int n;
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0;
        key_code  = '0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("busy_timeout", 1, 0);
    endtask

    typedef struct {
        logic [4:0] key;
        int disp;
        int err;
        int shr;
        int rem;
        int stb;
        int a;
        int b;
        int op;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(input logic [4:0] key, input int disp, input int err, input int shr,
                         input int rem, input int stb, input int a, input int b, input int op);
        vec_t v;
        v.key = key; v.disp = disp; v.err = err; v.shr = shr; v.rem = rem;
        v.stb = stb; v.a = a; v.b = b; v.op = op;
        vecs.push_back(v);
    endtask

    initial begin
        int s0;
        // key, disp, err, shr, rem, strobes, alu_a, alu_b, alu_op
        add_v(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add_v(2, 12, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 12, 0, 0, 0, 0, 0, 0, 0);
        add_v(10, 12, 0, 0, 0, 0, 0, 0, 0);
        add_v(3, 3, 0, 0, 0, 0, 0, 0, 0);
        add_v(4, 34, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 46, 0, 0, 0, 1, 12, 34, 0);
        add_v(5, 5, 0, 0, 0, 0, 0, 0, 0);
        add_v(11, 5, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 9, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, -4, 0, 0, 0, 1, 5, 9, 1);
        add_v(7, 7, 0, 0, 0, 0, 0, 0, 0);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 9, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 99, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 999, 0, 0, 0, 0, 0, 0, 0);
        add_v(12, 999, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 9, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 99, 0, 0, 0, 0, 0, 0, 0);
        add_v(9, 999, 0, 0, 0, 0, 0, 0, 0);
        add_v(16, -999, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, -998001, 0, 0, 0, 1, 999, -999, 2);
        add_v(10, 0, 1, 0, 0, 0, 0, 0, 0);
        add_v(5, 0, 1, 0, 0, 0, 0, 0, 0);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(7, 7, 0, 0, 0, 0, 0, 0, 0);
        add_v(16, -7, 0, 0, 0, 0, 0, 0, 0);
        add_v(13, -7, 0, 0, 0, 0, 0, 0, 0);
        add_v(2, 2, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, -4, 0, 1, 1, 1, -7, 2, 3);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(8, 8, 0, 0, 0, 0, 0, 0, 0);
        add_v(13, 8, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 0, 1, 0, 0, 0, 0, 0, 0);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add_v(2, 12, 0, 0, 0, 0, 0, 0, 0);
        add_v(3, 123, 0, 0, 0, 0, 0, 0, 0);
        add_v(4, 123, 0, 0, 0, 0, 0, 0, 0);
        add_v(12, 123, 0, 0, 0, 0, 0, 0, 0);
        add_v(3, 3, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 369, 0, 0, 0, 1, 123, 3, 2);
        add_v(10, 369, 0, 0, 0, 0, 0, 0, 0);
        add_v(4, 4, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 373, 0, 0, 0, 1, 369, 4, 0);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(16, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(5, -5, 0, 0, 0, 0, 0, 0, 0);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_v(4, 4, 0, 0, 0, 0, 0, 0, 0);
        add_v(2, 42, 0, 0, 0, 0, 0, 0, 0);
        add_v(1, 421, 0, 0, 0, 0, 0, 0, 0);
        add_v(10, 421, 0, 0, 0, 0, 0, 0, 0);
        add_v(11, 421, 0, 0, 0, 0, 0, 0, 0);
        add_v(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add_v(14, 420, 0, 0, 0, 1, 421, 1, 1);
        add_v(15, 0, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clock);
        chk("rst_disp", disp_s(), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_strobe", int'(alu_strobe), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_alu_b", int'(alu_b), 0);
        chk("rst_alu_op", int'(alu_op), 0);
        chk("rst_show_rem", int'(show_remainder), 0);
        chk("rst_rem", int'(display_remainder), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            s0 = strobe_cnt;
            press(vecs[i].key);
            $display("vec %0d key %0d -> display %0d error %0d show_rem %0d rem %0d",
                     i, vecs[i].key, disp_s(), error, show_remainder, display_remainder);
            chk($sformatf("v%0d_disp", i), disp_s(), vecs[i].disp);
            chk($sformatf("v%0d_error", i), int'(error), vecs[i].err);
            chk($sformatf("v%0d_show_rem", i), int'(show_remainder), vecs[i].shr);
            chk($sformatf("v%0d_rem", i), int'(display_remainder), vecs[i].rem);
            chk($sformatf("v%0d_strobes", i), strobe_cnt - s0, vecs[i].stb);
            if (vecs[i].stb != 0) begin
                chk($sformatf("v%0d_alu_a", i), last_a, vecs[i].a);
                chk($sformatf("v%0d_alu_b", i), last_b, vecs[i].b);
                chk($sformatf("v%0d_alu_op", i), last_op, vecs[i].op);
            end
        end

        // Keys during COMPUTE/WAIT are dropped, including clear; result lands 2 cycles after equals.
        press(2); press(10); press(3);
        s0 = strobe_cnt;
        key_code = 14; key_valid = 1'b1;
        @(negedge clock);
        key_code = 9;
        chk("lat_compute_busy", int'(busy), 1);
        chk("lat_compute_strobe", int'(alu_strobe), 1);
        @(negedge clock);
        key_code = 15;
        chk("lat_wait_busy", int'(busy), 1);
        chk("lat_wait_strobe", int'(alu_strobe), 0);
        @(negedge clock);
        key_valid = 1'b0; key_code = '0;
        $display("busy-drop seq -> display %0d busy %0d", disp_s(), busy);
        chk("lat_show_busy", int'(busy), 0);
        chk("lat_show_disp", disp_s(), 5);
        chk("lat_show_strobes", strobe_cnt - s0, 1);
        @(negedge clock);
        chk("lat_hold_disp", disp_s(), 5);

        // Asynchronous reset in the middle of WAIT.
        press(15); press(4); press(12); press(2);
        key_code = 14; key_valid = 1'b1;
        @(negedge clock);
        key_valid = 1'b0; key_code = '0;
        @(negedge clock);
        chk("rw_in_wait", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        $display("reset in WAIT -> display %0d busy %0d", disp_s(), busy);
        chk("rw_busy", int'(busy), 0);
        chk("rw_disp", disp_s(), 0);
        chk("rw_alu_a", int'(alu_a), 0);
        chk("rw_alu_b", int'(alu_b), 0);
        chk("rw_strobe", int'(alu_strobe), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rw_after_disp", disp_s(), 0);
        press(6);
        chk("rw_entry_a", disp_s(), 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
